// File: rtl/id_regfile_bypass.sv
// ID-stage register file: 31 GPRs plus HI/LO, WB commit, EX/MEM/WB operand bypass and load-use stall request.
// Optional HI/LO storage and bypass enabled by defining REGFILE_HILO_EN.
module id_regfile_bypass (
    input  logic        clk,
    input  logic        rst,
    input  logic [37:0] wb_to_rf,
    input  logic [65:0] wb_hilo,
    input  logic [37:0] ex_fwd,
    input  logic [37:0] mem_fwd,
    input  logic [65:0] ex_hilo,
    input  logic [65:0] mem_hilo,
    input  logic        ex_is_load,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    input  logic        re1,
    input  logic        re2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    output logic [31:0] hi_rdata,
    output logic [31:0] lo_rdata,
    output logic        stallreq
);

    logic        wb_we,    ex_we,    mem_we;
    logic [4:0]  wb_waddr, ex_waddr, mem_waddr;
    logic [31:0] wb_wdata, ex_wdata, mem_wdata;

    assign {wb_we,  wb_waddr,  wb_wdata}  = wb_to_rf;
    assign {ex_we,  ex_waddr,  ex_wdata}  = ex_fwd;
    assign {mem_we, mem_waddr, mem_wdata} = mem_fwd;

    // r0 is hardwired, so only r1..r31 are stored
    logic [31:0] gpr [1:31];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 1; i < 32; i++) begin
                gpr[i] <= '0;
            end
        end else if (wb_we && wb_waddr != '0) begin
            gpr[wb_waddr] <= wb_wdata;
        end
    end

    always_comb begin
        rdata1 = '0;
        if (raddr1 != '0) begin
            if (ex_we && ex_waddr == raddr1)        rdata1 = ex_wdata;
            else if (mem_we && mem_waddr == raddr1) rdata1 = mem_wdata;
            else if (wb_we && wb_waddr == raddr1)   rdata1 = wb_wdata;
            else                                    rdata1 = gpr[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (raddr2 != '0) begin
            if (ex_we && ex_waddr == raddr2)        rdata2 = ex_wdata;
            else if (mem_we && mem_waddr == raddr2) rdata2 = mem_wdata;
            else if (wb_we && wb_waddr == raddr2)   rdata2 = wb_wdata;
            else                                    rdata2 = gpr[raddr2];
        end
    end

    // A load in EX has no data yet; only used operands may request a stall
    assign stallreq = ex_is_load && ex_we && (ex_waddr != '0) &&
                      ((re1 && ex_waddr == raddr1) || (re2 && ex_waddr == raddr2));

`ifdef REGFILE_HILO_EN
    logic        wb_hi_we,  wb_lo_we,  ex_hi_we,  ex_lo_we,  mem_hi_we,  mem_lo_we;
    logic [31:0] wb_hi,     wb_lo,     ex_hi,     ex_lo,     mem_hi,     mem_lo;
    logic [31:0] hi_q, lo_q;

    assign {wb_hi_we,  wb_lo_we,  wb_hi,  wb_lo}  = wb_hilo;
    assign {ex_hi_we,  ex_lo_we,  ex_hi,  ex_lo}  = ex_hilo;
    assign {mem_hi_we, mem_lo_we, mem_hi, mem_lo} = mem_hilo;

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (wb_hi_we) hi_q <= wb_hi;
            if (wb_lo_we) lo_q <= wb_lo;
        end
    end

    always_comb begin
        hi_rdata = hi_q;
        if (ex_hi_we)       hi_rdata = ex_hi;
        else if (mem_hi_we) hi_rdata = mem_hi;
        else if (wb_hi_we)  hi_rdata = wb_hi;
    end

    always_comb begin
        lo_rdata = lo_q;
        if (ex_lo_we)       lo_rdata = ex_lo;
        else if (mem_lo_we) lo_rdata = mem_lo;
        else if (wb_lo_we)  lo_rdata = wb_lo;
    end
`else
    logic unused_hilo;
    assign unused_hilo = ^{wb_hilo, ex_hilo, mem_hilo};
    assign hi_rdata = '0;
    assign lo_rdata = '0;
`endif

endmodule

// File: tb/tb_id_regfile_bypass.sv
// Scoreboard bench for id_regfile_bypass: directed scenarios plus a randomized phase against a reference model.
// HI/LO expectations follow REGFILE_HILO_EN.
module tb_id_regfile_bypass;

    logic        clk = 1'b0;
    logic        rst;
    logic [37:0] wb_to_rf, ex_fwd, mem_fwd;
    logic [65:0] wb_hilo, ex_hilo, mem_hilo;
    logic        ex_is_load, re1, re2;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2, hi_rdata, lo_rdata;
    logic        stallreq;

    id_regfile_bypass dut (
        .clk(clk), .rst(rst),
        .wb_to_rf(wb_to_rf), .wb_hilo(wb_hilo),
        .ex_fwd(ex_fwd), .mem_fwd(mem_fwd),
        .ex_hilo(ex_hilo), .mem_hilo(mem_hilo),
        .ex_is_load(ex_is_load),
        .raddr1(raddr1), .raddr2(raddr2), .re1(re1), .re2(re2),
        .rdata1(rdata1), .rdata2(rdata2),
        .hi_rdata(hi_rdata), .lo_rdata(lo_rdata),
        .stallreq(stallreq)
    );

    always #5 clk = ~clk;

    localparam int SEL_RD1 = 0, SEL_RD2 = 1, SEL_HI = 2, SEL_LO = 3, SEL_STALL = 4;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic [31:0] ref_gpr [32];
    logic [31:0] ref_hi, ref_lo;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] hl_exp(input logic [31:0] v);
`ifdef REGFILE_HILO_EN
        return v;
`else
        return (v === v) ? 32'h0 : 32'h0;
`endif
    endfunction

    task automatic sample();
        exp_t        e;
        logic [31:0] obs;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                SEL_RD1: obs = rdata1;
                SEL_RD2: obs = rdata2;
                SEL_HI:  obs = hi_rdata;
                SEL_LO:  obs = lo_rdata;
                default: obs = {31'h0, stallreq};
            endcase
            check(e.tag, obs, e.val);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] bus(input logic we, input logic [4:0] a, input logic [31:0] d);
        return {we, a, d};
    endfunction

    function automatic logic [65:0] hl(input logic hw, input logic lw, input logic [31:0] h, input logic [31:0] l);
        return {hw, lw, h, l};
    endfunction

    task automatic idle();
        wb_to_rf = '0; ex_fwd = '0; mem_fwd = '0;
        wb_hilo = '0; ex_hilo = '0; mem_hilo = '0;
        ex_is_load = 1'b0; re1 = 1'b0; re2 = 1'b0;
    endtask

    function automatic logic [31:0] model_gpr(input logic [4:0] ra);
        if (ra == 5'd0) return 32'h0;
        if (ex_fwd[37] && ex_fwd[36:32] == ra)   return ex_fwd[31:0];
        if (mem_fwd[37] && mem_fwd[36:32] == ra) return mem_fwd[31:0];
        if (wb_to_rf[37] && wb_to_rf[36:32] == ra) return wb_to_rf[31:0];
        return ref_gpr[ra];
    endfunction

    function automatic logic [31:0] model_hi();
        if (ex_hilo[65])  return ex_hilo[63:32];
        if (mem_hilo[65]) return mem_hilo[63:32];
        if (wb_hilo[65])  return wb_hilo[63:32];
        return ref_hi;
    endfunction

    function automatic logic [31:0] model_lo();
        if (ex_hilo[64])  return ex_hilo[31:0];
        if (mem_hilo[64]) return mem_hilo[31:0];
        if (wb_hilo[64])  return wb_hilo[31:0];
        return ref_lo;
    endfunction

    function automatic logic model_stall();
        logic [4:0] a;
        a = ex_fwd[36:32];
        return ex_is_load && ex_fwd[37] && a != 5'd0 &&
               ((re1 && a == raddr1) || (re2 && a == raddr2));
    endfunction

    initial begin
        idle();
        raddr1 = 5'd3; raddr2 = 5'd0;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        push("rst_rd1", SEL_RD1, 32'h0); push("rst_rd2", SEL_RD2, 32'h0);
        push("rst_hi", SEL_HI, 32'h0);   push("rst_lo", SEL_LO, 32'h0);
        push("rst_stall", SEL_STALL, 32'h0);
        sample();

        step(); wb_to_rf = bus(1'b1, 5'd3, 32'h1234_5678);
        push("wt_r3", SEL_RD1, 32'h1234_5678); push("wt_r0", SEL_RD2, 32'h0);
        sample();
        step(); idle();
        push("arr_r3", SEL_RD1, 32'h1234_5678); push("arr_r0", SEL_RD2, 32'h0);
        sample();

        step();
        wb_to_rf = bus(1'b1, 5'd0, 32'hFFFF_FFFF);
        ex_fwd = bus(1'b1, 5'd0, 32'hEEEE_EEEE);
        mem_fwd = bus(1'b1, 5'd0, 32'hDDDD_DDDD);
        ex_is_load = 1'b1; re1 = 1'b1; re2 = 1'b1; raddr1 = 5'd0; raddr2 = 5'd0;
        push("r0_bus_rd1", SEL_RD1, 32'h0); push("r0_bus_rd2", SEL_RD2, 32'h0);
        push("r0_no_stall", SEL_STALL, 32'h0);
        sample();
        step(); idle();
        push("r0_after", SEL_RD1, 32'h0);
        sample();

        step(); wb_to_rf = bus(1'b1, 5'd7, 32'h1); raddr1 = 5'd7; raddr2 = 5'd7;
        push("r7_wt1", SEL_RD1, 32'h1);
        sample();
        step();
        wb_to_rf = bus(1'b1, 5'd7, 32'h2);
        mem_fwd = bus(1'b1, 5'd7, 32'h3);
        ex_fwd = bus(1'b1, 5'd7, 32'h4);
        re1 = 1'b1; re2 = 1'b1;
        push("pri_ex_rd1", SEL_RD1, 32'h4); push("pri_ex_rd2", SEL_RD2, 32'h4);
        push("pri_nonload_stall", SEL_STALL, 32'h0);
        sample();
        step(); ex_fwd = '0;
        push("pri_mem", SEL_RD1, 32'h3);
        sample();
        step(); mem_fwd = '0;
        push("pri_wb", SEL_RD1, 32'h2);
        sample();
        step(); idle();
        push("r7_arr", SEL_RD1, 32'h2);
        sample();

        step();
        ex_is_load = 1'b1; ex_fwd = bus(1'b1, 5'd9, 32'hDEAD_BEEF);
        raddr1 = 5'd0; raddr2 = 5'd9; re2 = 1'b1;
        push("lu_stall_re2", SEL_STALL, 32'h1); push("lu_ex_data", SEL_RD2, 32'hDEAD_BEEF);
        sample();
        step(); re2 = 1'b0;
        push("lu_re2_off", SEL_STALL, 32'h0);
        sample();
        step(); raddr1 = 5'd9; re1 = 1'b1;
        push("lu_stall_re1", SEL_STALL, 32'h1);
        sample();
        step();
        ex_is_load = 1'b0; ex_fwd = '0; mem_fwd = bus(1'b1, 5'd9, 32'hABCD); re2 = 1'b1;
        push("lu_mem_stall", SEL_STALL, 32'h0);
        push("lu_mem_rd1", SEL_RD1, 32'hABCD); push("lu_mem_rd2", SEL_RD2, 32'hABCD);
        sample();

        step(); idle(); wb_hilo = hl(1'b1, 1'b0, 32'hAA, 32'hBB);
        push("hl_wt_hi", SEL_HI, hl_exp(32'hAA)); push("hl_wt_lo", SEL_LO, 32'h0);
        sample();
        step(); idle();
        push("hl_arr_hi", SEL_HI, hl_exp(32'hAA)); push("hl_arr_lo", SEL_LO, 32'h0);
        sample();
        step();
        mem_hilo = hl(1'b0, 1'b1, 32'h77, 32'hCC);
        ex_hilo = hl(1'b1, 1'b0, 32'h11, 32'h99);
        push("hl_ex_hi", SEL_HI, hl_exp(32'h11)); push("hl_mem_lo", SEL_LO, hl_exp(32'hCC));
        sample();

        step(); idle();
        rst = 1'b1; wb_to_rf = bus(1'b1, 5'd4, 32'h55); raddr1 = 5'd4; raddr2 = 5'd7;
        step(); idle(); rst = 1'b0;
        push("mid_rst_r4", SEL_RD1, 32'h0); push("mid_rst_r7", SEL_RD2, 32'h0);
        push("mid_rst_hi", SEL_HI, 32'h0);
        sample();

        for (int i = 0; i < 32; i++) ref_gpr[i] = 32'h0;
        ref_hi = 32'h0; ref_lo = 32'h0;
        for (int n = 0; n < 300; n++) begin
            step();
            wb_to_rf = bus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            mem_fwd  = bus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            ex_fwd   = bus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            wb_hilo  = hl(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
            mem_hilo = hl(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), $urandom, $urandom);
            ex_hilo  = hl(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), $urandom, $urandom);
            ex_is_load = 1'($urandom_range(0, 1));
            re1 = 1'($urandom_range(0, 1)); re2 = 1'($urandom_range(0, 1));
            raddr1 = 5'($urandom_range(0, 7)); raddr2 = 5'($urandom_range(0, 7));
            push("rnd_rd1", SEL_RD1, model_gpr(raddr1));
            push("rnd_rd2", SEL_RD2, model_gpr(raddr2));
            push("rnd_hi", SEL_HI, hl_exp(model_hi()));
            push("rnd_lo", SEL_LO, hl_exp(model_lo()));
            push("rnd_stall", SEL_STALL, {31'h0, model_stall()});
            sample();
            if (wb_to_rf[37] && wb_to_rf[36:32] != 5'd0) ref_gpr[wb_to_rf[36:32]] = wb_to_rf[31:0];
            if (wb_hilo[65]) ref_hi = wb_hilo[63:32];
            if (wb_hilo[64]) ref_lo = wb_hilo[31:0];
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/id_regfile_bypass.md
# id_regfile_bypass

Register-file end of the write-back path: stores the 32 GPRs plus HI/LO and accepts commits from the WB-stage buses. Serves ID-stage operand reads with full bypassing from the EX, MEM and WB result buses. Raises a load-use stall request toward the stall controller. Sits inside ID; owns all architectural GPR/HI/LO state.

## Interface
Parameters:
- none (bus widths fixed: GPR bus 38 bits, HI/LO bus 66 bits)

Ports (clock and reset: clk, rst; reset is synchronous, active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wb_to_rf  in  38  {we, waddr[4:0], wdata[31:0]}: commit bus from WB
- wb_hilo  in  66  {hi_we, lo_we, hi[31:0], lo[31:0]}: HI/LO commit bus from WB
- ex_fwd, mem_fwd  in  38 each  same format as wb_to_rf; results in flight
- ex_hilo, mem_hilo  in  66 each  same format as wb_hilo
- ex_is_load  in  1  instruction in EX is a load; its ex_fwd data is not yet valid
- raddr1, raddr2  in  5  ID source register numbers (rs, rt)
- re1, re2  in  1  operand actually used by the ID instruction
- rdata1, rdata2  out  32  bypassed operand values
- hi_rdata, lo_rdata  out  32  bypassed HI/LO values
- stallreq  out  1  load-use stall request to stall controller

## Operation
- Storage: 31 x 32-bit GPRs (r1..r31), HI, LO. r0 reads 0 and is never written; we with waddr 0 is dropped on every bus.
- Commit: at posedge clk, rst low: wb we=1 → gpr[waddr] <= wdata; hi_we → HI <= hi; lo_we → LO <= lo; hi_we and lo_we independent.
- GPR read, per port, raddr != 0, priority first match: EX (we && waddr==raddr) → MEM → WB → array. raddr==0 → 0 regardless of buses.
- HI read priority EX.hi_we → MEM.hi_we → WB.hi_we → HI register; LO identical using lo_we/lo fields.
- Load-use: stallreq = ex_is_load && ex.we && ex.waddr!=0 && ((re1 && ex.waddr==raddr1) || (re2 && ex.waddr==raddr2)).
- While stallreq=1 the matching rdata carries the EX match (garbage); ID discards it, and the consumer re-reads after the load reaches MEM.
- re1/re2 gate stallreq only; rdata is always produced.
- No internal state besides storage; all read/forward/stall logic is combinational.

## Timing
- Reset: on posedge clk with rst=1 all GPRs, HI, LO <= 0; WB commit in that same cycle is discarded. rst mid-stream: state zeroed next edge, buses honoured from the first edge with rst=0.
- Outputs after reset with all buses idle: rdata1=rdata2=hi_rdata=lo_rdata=0, stallreq=0.
- Read latency 0 cycles (combinational from raddr and buses).
- Write latency 1 edge; same-cycle read of the address being committed returns the new wdata via WB bypass (write-through), never the stale array value.
- Simultaneous matches on EX, MEM, WB to one address: EX wins. EX load match wins priority but asserts stallreq.
- rdata1 and rdata2 may target the same register; both get identical value.
- stallreq is combinational; the stall controller holds ID and bubbles EX. Next cycle the load sits in MEM, whose data is valid, so stallreq drops after exactly one cycle for a single load-use pair.

## Configuration
- Macro REGFILE_HILO_EN.
- Defined: HI/LO registers, commit from wb_hilo and EX/MEM/WB HI/LO bypass as above.
- Undefined: no HI/LO storage; wb_hilo, ex_hilo, mem_hilo ignored; hi_rdata=lo_rdata=0 constantly. GPR behaviour unchanged. Ports remain present in both builds.

## Test plan
- Reset, then wb_to_rf={1,5'd3,32'h1234_5678} one edge; idle buses; raddr1=3 → rdata1=32'h1234_5678; raddr2=0 → rdata2=0.
- WB writes r0 with 32'hFFFF_FFFF, EX and MEM also target r0 → rdata for raddr=0 is 0; after edge r0 still reads 0.
- r7 array=32'h1, WB=32'h2, MEM=32'h3, EX=32'h4 to r7, ex_is_load=0 → rdata1=32'h4; drop EX → 32'h3; drop MEM → 32'h2 (same-cycle write-through).
- ex_is_load=1, ex_fwd={1,5'd9,x}, raddr2=9, re2=1 → stallreq=1; same with re2=0 → stallreq=0; next cycle load in MEM with 32'hABCD → stallreq=0, rdata2=32'hABCD.
- REGFILE_HILO_EN defined: wb_hilo={1,0,32'hAA,32'hBB} commits HI=32'hAA, LO unchanged 0; mem_hilo lo_we=1 lo=32'hCC → lo_rdata=32'hCC. Undefined build: same stimulus → hi_rdata=lo_rdata=0.
- rst asserted while wb_to_rf writes r4=32'h55 → after edge r4 reads 0.
